// File: rtl/dwconv_pkg.sv
// dwconv_pkg: shared types and widths for the dwconv blocks.
package dwconv_pkg;

  localparam int W_BITS = 144;
  localparam int B_BITS = 16;
  localparam int D_BITS = 16;

  typedef enum logic [2:0] {
    IDLE,
    LDW,
    CAPW,
    STRM,
    DRN,
    FIN
  } sched_state_e;

endpackage

// File: rtl/dwconv_sched_if.sv
// dwconv_sched_if: buffer-memory and dwconv-datapath signals of the scheduler.
interface dwconv_sched_if #(
  parameter int ADDR_W = 16,
  parameter int CH_W   = 6
);
  import dwconv_pkg::*;

  logic                     wmem_rd;
  logic [CH_W-1:0]          wmem_addr;
  logic [B_BITS+W_BITS-1:0] wmem_rdata;
  logic                     fmem_rd;
  logic [ADDR_W-1:0]        fmem_addr;
  logic [D_BITS-1:0]        fmem_rdata;
  logic                     dw_in_valid;
  logic [D_BITS-1:0]        dw_in_data;
  logic [W_BITS-1:0]        dw_weight;
  logic [B_BITS-1:0]        dw_bias;
  logic                     dw_out_valid;
  logic [D_BITS-1:0]        dw_sum;
  logic                     omem_wr;
  logic [ADDR_W-1:0]        omem_addr;
  logic [D_BITS-1:0]        omem_wdata;

  modport master (
    output wmem_rd, wmem_addr, fmem_rd, fmem_addr,
    output dw_in_valid, dw_in_data, dw_weight, dw_bias,
    output omem_wr, omem_addr, omem_wdata,
    input  wmem_rdata, fmem_rdata, dw_out_valid, dw_sum
  );

  modport slave (
    input  wmem_rd, wmem_addr, fmem_rd, fmem_addr,
    input  dw_in_valid, dw_in_data, dw_weight, dw_bias,
    input  omem_wr, omem_addr, omem_wdata,
    output wmem_rdata, fmem_rdata, dw_out_valid, dw_sum
  );

endinterface

// File: rtl/dwconv_sched_addr.sv
// dwconv_sched_addr: per-job base, per-channel pixel/output counters and the
// feature/output address adders (results wrap at ADDR_W).
module dwconv_sched_addr #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_job_start,
  input  logic              i_ch_start,
  input  logic              i_pix_inc,
  input  logic              i_ocnt_inc,
  input  logic              i_ch_done,
  input  logic [ADDR_W-1:0] i_n,
  output logic [ADDR_W-1:0] o_fmem_addr,
  output logic [ADDR_W-1:0] o_omem_addr,
  output logic              o_pix_last,
  output logic              o_ocnt_full
);

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_pix;
  logic [ADDR_W-1:0] r_ocnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_pix  <= '0;
      r_ocnt <= '0;
    end else begin
      if (i_job_start)    r_base <= '0;
      else if (i_ch_done) r_base <= r_base + i_n;

      if (i_ch_start)     r_pix <= '0;
      else if (i_pix_inc) r_pix <= o_pix_last ? '0 : r_pix + ADDR_W'(1);

      if (i_ch_start)      r_ocnt <= '0;
      else if (i_ocnt_inc) r_ocnt <= r_ocnt + ADDR_W'(1);
    end
  end

  assign o_fmem_addr = r_base + r_pix;
  assign o_omem_addr = r_base + r_ocnt;
  assign o_pix_last  = (r_pix == i_n - ADDR_W'(1));
  assign o_ocnt_full = (r_ocnt == i_n);

endmodule

// File: rtl/dwconv_sched.sv
// dwconv_sched: walks cfg_ch channels, loading weights, streaming pixels into
// dwconv and writing sums back. Drain watchdog built when DWCONV_SCHED_TIMEOUT_EN is defined.
module dwconv_sched
  import dwconv_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DIM_W   = 7,
  parameter int CH_W    = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [DIM_W-1:0] i_cfg_w,
  input  logic [DIM_W-1:0] i_cfg_h,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  dwconv_sched_if.master   bus
);

  sched_state_e      r_state, w_next;
  logic [CH_W-1:0]   r_cfg_ch, r_ch;
  logic [ADDR_W-1:0] r_n, w_n;
  logic [W_BITS-1:0] r_weight;
  logic [B_BITS-1:0] r_bias;
  logic              r_rd_d1, r_busy, r_done, r_err;
  logic              r_omem_wr;
  logic [ADDR_W-1:0] r_omem_addr;
  logic [D_BITS-1:0] r_omem_wdata;
  logic              w_wmem_rd, w_fmem_rd;
  logic              w_accept, w_capture, w_ocnt_inc, w_spurious;
  logic              w_ch_done, w_last_ch, w_timeout, w_pix_last, w_ocnt_full;
  logic [ADDR_W-1:0] w_fmem_addr, w_omem_addr;

  assign w_n = {{(ADDR_W-DIM_W){1'b0}}, i_cfg_w} * {{(ADDR_W-DIM_W){1'b0}}, i_cfg_h};
  assign w_accept    = (r_state == IDLE) && i_start;
  assign w_capture   = (r_state == STRM) || (r_state == DRN);
  assign w_ocnt_inc  = bus.dw_out_valid && w_capture && !w_ocnt_full;
  assign w_spurious  = bus.dw_out_valid && !w_ocnt_inc;
  assign w_ch_done   = (r_state == DRN) && w_ocnt_full;
  assign w_last_ch   = ((r_ch + CH_W'(1)) == r_cfg_ch);

`ifdef DWCONV_SCHED_TIMEOUT_EN
  localparam int DRN_W = $clog2(TIMEOUT + 1);
  logic [DRN_W-1:0] r_drn_cnt;

  // Restarts on every returned sum, so only a silent datapath trips it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_drn_cnt <= '0;
    else if (r_state != DRN || bus.dw_out_valid)  r_drn_cnt <= '0;
    else if (!w_timeout)                          r_drn_cnt <= r_drn_cnt + DRN_W'(1);
  end

  assign w_timeout = (r_state == DRN) && (r_drn_cnt == DRN_W'(TIMEOUT));
`else
  assign w_timeout = (TIMEOUT < 0);
`endif

  always_comb begin
    w_next    = r_state;
    w_wmem_rd = 1'b0;
    w_fmem_rd = 1'b0;
    unique case (r_state)
      IDLE: if (i_start) w_next = (i_cfg_ch == '0 || w_n == '0) ? FIN : LDW;
      LDW: begin
        w_wmem_rd = 1'b1;
        w_next    = CAPW;
      end
      CAPW: w_next = STRM;
      STRM: begin
        w_fmem_rd = 1'b1;
        if (w_pix_last) w_next = DRN;
      end
      DRN: begin
        if (w_ch_done)      w_next = w_last_ch ? FIN : LDW;
        else if (w_timeout) w_next = FIN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cfg_ch     <= '0;
      r_ch         <= '0;
      r_n          <= '0;
      r_weight     <= '0;
      r_bias       <= '0;
      r_rd_d1      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_omem_wr    <= 1'b0;
      r_omem_addr  <= '0;
      r_omem_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cfg_ch <= i_cfg_ch;
        r_n      <= w_n;
        r_ch     <= '0;
      end else if (w_ch_done) begin
        r_ch <= r_ch + CH_W'(1);
      end
      if (r_state == CAPW) begin
        r_weight <= bus.wmem_rdata[W_BITS-1:0];
        r_bias   <= bus.wmem_rdata[B_BITS+W_BITS-1:W_BITS];
      end
      r_rd_d1   <= w_fmem_rd;
      r_busy    <= (w_next != IDLE);
      r_done    <= (r_state == FIN);
      r_omem_wr <= w_ocnt_inc;
      if (w_ocnt_inc) begin
        r_omem_addr  <= w_omem_addr;
        r_omem_wdata <= bus.dw_sum;
      end
      // A late error in the same cycle as a new start is kept, not cleared.
      if (w_spurious || w_timeout) r_err <= 1'b1;
      else if (w_accept)           r_err <= 1'b0;
    end
  end

  dwconv_sched_addr #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk         (clk),
    .rst         (rst),
    .i_job_start (w_accept),
    .i_ch_start  (w_wmem_rd),
    .i_pix_inc   (w_fmem_rd),
    .i_ocnt_inc  (w_ocnt_inc),
    .i_ch_done   (w_ch_done),
    .i_n         (r_n),
    .o_fmem_addr (w_fmem_addr),
    .o_omem_addr (w_omem_addr),
    .o_pix_last  (w_pix_last),
    .o_ocnt_full (w_ocnt_full)
  );

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_err           = r_err;
  assign bus.wmem_rd     = w_wmem_rd;
  assign bus.wmem_addr   = w_wmem_rd ? r_ch : '0;
  assign bus.fmem_rd     = w_fmem_rd;
  assign bus.fmem_addr   = w_fmem_rd ? w_fmem_addr : '0;
  assign bus.dw_in_valid = r_rd_d1;
  assign bus.dw_in_data  = r_rd_d1 ? bus.fmem_rdata : '0;
  assign bus.dw_weight   = r_weight;
  assign bus.dw_bias     = r_bias;
  assign bus.omem_wr     = r_omem_wr;
  assign bus.omem_addr   = r_omem_addr;
  assign bus.omem_wdata  = r_omem_wdata;

endmodule

// File: tb/tb_dwconv_sched.sv
// tb_dwconv_sched: random memories and a 5-cycle dwconv stub drive dwconv_sched;
// expected reads/writes come from a per-channel reference built from the tables.
module tb_dwconv_sched;
  import dwconv_pkg::*;

`ifdef DWCONV_SCHED_TIMEOUT_EN
  localparam int TB_TIMEOUT = 32;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic [5:0] i_cfg_ch = '0;
  logic [6:0] i_cfg_w = '0;
  logic [6:0] i_cfg_h = '0;
  logic       o_busy, o_done, o_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dwconv_sched_if #(.ADDR_W(16), .CH_W(6)) bus ();

  dwconv_sched #(
    .ADDR_W(16), .DIM_W(7), .CH_W(6), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_cfg_ch(i_cfg_ch), .i_cfg_w(i_cfg_w), .i_cfg_h(i_cfg_h),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .bus(bus)
  );

  // Buffer memories with one-cycle read latency.
  logic [159:0] wmem [64];
  logic [15:0]  fmem [256];

  always @(posedge clk) begin
    if (bus.wmem_rd) bus.wmem_rdata <= wmem[bus.wmem_addr];
    if (bus.fmem_rd) bus.fmem_rdata <= fmem[bus.fmem_addr[7:0]];
  end

  // dwconv stub: 5-cycle latency, optionally swallowing input number drop_idx.
  logic [4:0]  pv;
  logic [15:0] ps [5];
  int          in_cnt;
  int          drop_idx = -1;
  logic        inj = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv     <= '0;
      in_cnt <= 0;
      for (int i = 0; i < 5; i++) ps[i] <= '0;
    end else begin
      if (i_start)              in_cnt <= 0;
      else if (bus.dw_in_valid) in_cnt <= in_cnt + 1;
      pv    <= {pv[3:0], bus.dw_in_valid && (in_cnt != drop_idx)};
      ps[0] <= bus.dw_in_data + bus.dw_bias + bus.dw_weight[15:0] + bus.dw_weight[143:128];
      for (int i = 1; i < 5; i++) ps[i] <= ps[i-1];
    end
  end

  assign bus.dw_out_valid = pv[4] | inj;
  assign bus.dw_sum       = ps[4];

  // Monitor: logs every strobe seen on the memory side.
  logic [15:0]  fq [$];
  logic [5:0]   wq [$];
  logic [15:0]  oaq [$];
  logic [15:0]  odq [$];
  int           done_cnt = 0;
  int           wchg = 0;
  int           cyc_ctr = 0;
  int           last_wr_cyc = 0;
  logic         prev_rd = 1'b0;
  logic [143:0] prev_w = '0;

  always @(negedge clk) begin
    cyc_ctr++;
    if (bus.fmem_rd) fq.push_back(bus.fmem_addr);
    if (bus.wmem_rd) wq.push_back(bus.wmem_addr);
    if (bus.omem_wr) begin
      oaq.push_back(bus.omem_addr);
      odq.push_back(bus.omem_wdata);
      last_wr_cyc = cyc_ctr;
    end
    if (o_done) done_cnt++;
    if (bus.fmem_rd && prev_rd && bus.dw_weight !== prev_w) wchg++;
    prev_rd = bus.fmem_rd;
    prev_w  = bus.dw_weight;
  end

  function automatic logic [15:0] expSum(input int c, input int a);
    logic [159:0] wv;
    wv = wmem[c];
    return fmem[a % 256] + wv[159:144] + wv[15:0] + wv[143:128];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int ch, input int w, input int h);
    i_start  = 1'b1;
    i_cfg_ch = 6'(ch);
    i_cfg_w  = 7'(w);
    i_cfg_h  = 7'(h);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit seen);
    int cyc = 0;
    while (!o_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    seen = o_done;
  endtask

  task automatic runJob(input string tag, input int ch, input int w, input int h, input bit mid_start);
    int n, f0, w0, o0, d0, c0, cyc, a, nf, no, nw;
    bit seen;
    n  = w * h;
    f0 = fq.size(); w0 = wq.size(); o0 = oaq.size(); d0 = done_cnt; c0 = wchg;
    $display("[TB] job %s: ch=%0d w=%0d h=%0d", tag, ch, w, h);
    applyStimulus(ch, w, h);
    checkOutput({tag, "_err_clr"}, o_err, 0);
    checkOutput({tag, "_busy"}, o_busy, 1);
    if (mid_start) begin
      cyc = 0;
      while (!bus.fmem_rd && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput({tag, "_in_strm"}, bus.fmem_rd, 1);
      applyStimulus(5, 7, 7);
    end
    waitDone(20000, seen);
    checkOutput({tag, "_done_seen"}, seen, 1);
    checkOutput({tag, "_busy_drop"}, o_busy, 0);
    checkOutput({tag, "_err"}, o_err, 0);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_done_once"}, done_cnt - d0, 1);
    checkOutput({tag, "_w_stable"}, wchg - c0, 0);
    nw = wq.size() - w0;
    nf = fq.size() - f0;
    no = oaq.size() - o0;
    checkOutput({tag, "_wrd_cnt"}, nw, ch);
    for (int c = 0; c < ch && c < nw; c++) checkOutput({tag, "_waddr"}, wq[w0+c], c);
    checkOutput({tag, "_frd_cnt"}, nf, ch * n);
    checkOutput({tag, "_owr_cnt"}, no, ch * n);
    for (int c = 0; c < ch; c++) begin
      for (int p = 0; p < n; p++) begin
        a = (c * n + p) % 65536;
        if (c * n + p < nf) checkOutput({tag, "_faddr"}, fq[f0 + c*n + p], a);
        if (c * n + p < no) begin
          checkOutput({tag, "_oaddr"}, oaq[o0 + c*n + p], a);
          checkOutput({tag, "_odata"}, odq[o0 + c*n + p], expSum(c, a));
        end
      end
    end
  endtask

  task automatic zeroJob(input string tag, input int ch, input int w, input int h);
    int f0, w0, o0;
    f0 = fq.size(); w0 = wq.size(); o0 = oaq.size();
    applyStimulus(ch, w, h);
    checkOutput({tag, "_busy1"}, {o_busy, o_done}, 2'b10);
    @(negedge clk);
    checkOutput({tag, "_done2"}, {o_busy, o_done}, 2'b01);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, o_done, 0);
    checkOutput({tag, "_no_strobe"}, (fq.size() - f0) + (wq.size() - w0) + (oaq.size() - o0), 0);
    checkOutput({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    int o0, d0, gap;
    bit seen;
    for (int i = 0; i < 64; i++) wmem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 256; i++) fmem[i] = 16'($urandom);

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_status", {o_busy, o_done, o_err}, 0);
    checkOutput("rst_strobes", {bus.wmem_rd, bus.fmem_rd, bus.omem_wr, bus.dw_in_valid}, 0);
    checkOutput("rst_weight", |bus.dw_weight, 0);
    rst = 1'b0;
    @(negedge clk);

    runJob("single", 1, 4, 4, 0);
    runJob("three_ch", 3, 3, 2, 0);
    for (int k = 0; k < 3; k++)
      runJob("rand", $urandom_range(1, 4), $urandom_range(1, 6), $urandom_range(1, 6), 0);

    zeroJob("zero_ch", 0, 4, 4);
    zeroJob("zero_w", 2, 0, 5);
    runJob("back2back", 1, 2, 2, 0);

    runJob("mid_start", 1, 4, 4, 1);

    o0 = oaq.size();
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    checkOutput("spur_err", o_err, 1);
    @(negedge clk);
    checkOutput("spur_no_wr", oaq.size() - o0, 0);
    checkOutput("spur_idle", o_busy, 0);
    runJob("after_spur", 2, 2, 3, 0);

    drop_idx = 15;
    o0 = oaq.size();
    d0 = done_cnt;
    applyStimulus(1, 4, 4);
`ifdef DWCONV_SCHED_TIMEOUT_EN
    waitDone(2000, seen);
    gap = cyc_ctr - last_wr_cyc;
    checkOutput("to_done", seen, 1);
    checkOutput("to_err", o_err, 1);
    checkOutput("to_gap", (gap >= 30 && gap <= 40), 1);
`else
    repeat (1000) @(negedge clk);
    checkOutput("hang_busy", o_busy, 1);
    checkOutput("hang_no_done", done_cnt - d0, 0);
`endif
    checkOutput("drop_wr_cnt", oaq.size() - o0, 15);
    drop_idx = -1;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(2, 4, 4);
    gap = 0;
    while (!bus.fmem_rd && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_strm", bus.fmem_rd, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_status", {o_busy, o_done, o_err}, 0);
    checkOutput("mid_rst_strobes", {bus.wmem_rd, bus.fmem_rd, bus.omem_wr, bus.dw_in_valid}, 0);
    checkOutput("mid_rst_data", {|bus.fmem_addr, |bus.dw_weight, |bus.dw_bias, |bus.omem_addr, |bus.omem_wdata, |bus.dw_in_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runJob("after_rst", 2, 4, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
